// File: rtl/present80_keysched_if.sv
// rtl/present80_keysched_if.sv - round-key generator load/stream interface
// Groups the key-load request and the round-key valid/ready stream with its status flags.
interface present80_keysched_if;
    logic        start;
    logic [79:0] key_in;
    logic        rk_ready;
    logic        rk_valid;
    logic [63:0] rk_out;
    logic [5:0]  rk_round;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output key_in,
        output rk_ready,
        input  rk_valid,
        input  rk_out,
        input  rk_round,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  key_in,
        input  rk_ready,
        output rk_valid,
        output rk_out,
        output rk_round,
        output busy,
        output done
    );
endinterface

// File: rtl/present80_keysched.sv
// rtl/present80_keysched.sv - PRESENT-80 sequential round-key generator
// Latches an 80-bit key and emits rk1..rk32, advancing the key register once per consumed round key.
module present80_keysched (
    input  logic                 clk,
    input  logic                 rst_n,
    present80_keysched_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [79:0] key_q;
    logic [5:0]  round_q;
    logic        done_q;
    logic        hs;
    logic        last;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One key-schedule step: rotate left 61, S-box the top nibble, fold the round counter in.
    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ r;
        return t;
    endfunction

    assign hs   = (state == RUN) && bus.rk_ready;
    assign last = (round_q == 6'd32);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (hs && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // K only moves on a load or a consumed key below rk32; it keeps its final value after rk32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= 80'd0;
            round_q <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= hs && last;
            if (state == IDLE) begin
                if (bus.start) begin
                    key_q   <= bus.key_in;
                    round_q <= 6'd1;
                end
            end else if (hs) begin
                if (last) begin
                    round_q <= 6'd0;
                end else begin
                    key_q   <= key_update(key_q, round_q[4:0]);
                    round_q <= round_q + 6'd1;
                end
            end
        end
    end

    always_comb begin
        bus.rk_valid = (state == RUN);
        bus.busy     = (state == RUN);
        bus.rk_out   = key_q[79:16];
        bus.rk_round = round_q;
        bus.done     = done_q;
    end

endmodule

// File: tb/tb_present80_keysched.sv
// tb/tb_present80_keysched.sv - self-checking bench for present80_keysched
// Random keys and handshakes checked against a schedule computed from the PRESENT-80 key rules.
module tb_present80_keysched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    present80_keysched_if bus ();

    present80_keysched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] exp_rk [1:32];
    logic [3:0]  sbox_tbl [16];

    // Reference schedule from the published rules: rotate, S-box, counter XOR.
    function automatic void build_sched(input logic [79:0] key);
        logic [79:0] k;
        k = key;
        for (int r = 1; r <= 32; r++) begin
            exp_rk[r] = k[79:16];
            if (r < 32) begin
                k = (k << 61) | (k >> 19);
                k[79:76] = sbox_tbl[k[79:76]];
                k = k ^ (80'(r) << 15);
            end
        end
    endfunction

    function automatic logic [79:0] rand_key();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    task automatic start_key(input logic [79:0] key);
        bus.start  = 1'b1;
        bus.key_in = key;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.key_in = 80'd0; bus.rk_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.rk_valid, bus.busy, bus.done, bus.rk_out, bus.rk_round} !== 73'd0) begin
            tests_failed++;
            $display("FAIL reset_values got v=%0b b=%0b d=%0b rk=%h r=%0d want all zero",
                     bus.rk_valid, bus.busy, bus.done, bus.rk_out, bus.rk_round);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.rk_valid !== 1'b0 || bus.rk_round !== 6'd0) begin
            tests_failed++;
            $display("FAIL idle_after_reset got v=%0b r=%0d want v=0 r=0", bus.rk_valid, bus.rk_round);
        end
    endtask

    task automatic test_zero_key;
        logic [63:0] fixed [1:3];
        fixed[1] = 64'h0000000000000000;
        fixed[2] = 64'hC000000000000000;
        fixed[3] = 64'h5000180000000001;
        build_sched(80'd0);
        bus.rk_ready = 1'b1;
        start_key(80'd0);
        for (int r = 1; r <= 32; r++) begin
            tests_run++;
            if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.rk_round !== 6'(r) ||
                bus.rk_out !== exp_rk[r]) begin
                tests_failed++;
                $display("FAIL zero_key_rk%0d got v=%0b r=%0d rk=%h want v=1 r=%0d rk=%h",
                         r, bus.rk_valid, bus.rk_round, bus.rk_out, r, exp_rk[r]);
            end
            if (r <= 3) begin
                tests_run++;
                if (bus.rk_out !== fixed[r]) begin
                    tests_failed++;
                    $display("FAIL zero_key_const_rk%0d got %h want %h", r, bus.rk_out, fixed[r]);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.rk_valid !== 1'b0 || bus.rk_round !== 6'd0) begin
            tests_failed++;
            $display("FAIL zero_key_done got d=%0b b=%0b v=%0b r=%0d want d=1 b=0 v=0 r=0",
                     bus.done, bus.busy, bus.rk_valid, bus.rk_round);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_key_done_pulse got d=%0b want 0", bus.done);
        end
    endtask

    task automatic test_backpressure;
        int idx;
        int cyc;
        logic prev_rdy;
        logic [63:0] prev_rk;
        logic [5:0] prev_rnd;
        build_sched({80{1'b1}});
        bus.rk_ready = 1'b0;
        start_key({80{1'b1}});
        tests_run++;
        if (bus.rk_out !== 64'hFFFFFFFFFFFFFFFF) begin
            tests_failed++;
            $display("FAIL bp_rk1_const got %h want ffffffffffffffff", bus.rk_out);
        end
        idx = 1; cyc = 0; prev_rdy = 1'b1; prev_rk = '0; prev_rnd = '0;
        while (idx <= 32 && cyc < 2000) begin
            tests_run++;
            if (bus.rk_valid !== 1'b1 || bus.rk_round !== 6'(idx) || bus.rk_out !== exp_rk[idx]) begin
                tests_failed++;
                $display("FAIL bp_rk%0d got v=%0b r=%0d rk=%h want v=1 r=%0d rk=%h",
                         idx, bus.rk_valid, bus.rk_round, bus.rk_out, idx, exp_rk[idx]);
            end
            if (!prev_rdy) begin
                tests_run++;
                if (bus.rk_out !== prev_rk || bus.rk_round !== prev_rnd) begin
                    tests_failed++;
                    $display("FAIL bp_hold got rk=%h r=%0d want rk=%h r=%0d",
                             bus.rk_out, bus.rk_round, prev_rk, prev_rnd);
                end
            end
            prev_rk = bus.rk_out; prev_rnd = bus.rk_round;
            bus.rk_ready = 1'($urandom_range(0, 1));
            prev_rdy = bus.rk_ready;
            if (bus.rk_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (idx <= 32 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_done got idx=%0d d=%0b want idx=33 d=1", idx, bus.done);
        end
        bus.rk_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_busy;
        logic [79:0] key;
        key = rand_key();
        build_sched(key);
        bus.rk_ready = 1'b1;
        start_key(key);
        for (int r = 1; r <= 32; r++) begin
            tests_run++;
            if (bus.rk_valid !== 1'b1 || bus.rk_round !== 6'(r) || bus.rk_out !== exp_rk[r]) begin
                tests_failed++;
                $display("FAIL start_busy_rk%0d got r=%0d rk=%h want r=%0d rk=%h",
                         r, bus.rk_round, bus.rk_out, r, exp_rk[r]);
            end
            bus.start  = (r == 10);
            bus.key_in = ~key;
            @(negedge clk);
        end
        bus.start = 1'b0;
        tests_run++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_busy_done got d=%0b b=%0b want d=1 b=0", bus.done, bus.busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [79:0] key;
        key = rand_key();
        bus.rk_ready = 1'b1;
        start_key(key);
        repeat (16) @(negedge clk);
        tests_run++;
        if (bus.rk_round !== 6'd17) begin
            tests_failed++;
            $display("FAIL rst_mid_round got %0d want 17", bus.rk_round);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.rk_valid, bus.busy, bus.done, bus.rk_out, bus.rk_round} !== 73'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_async got v=%0b b=%0b d=%0b rk=%h r=%0d want all zero",
                     bus.rk_valid, bus.busy, bus.done, bus.rk_out, bus.rk_round);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_done got d=%0b want 0", bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        key = rand_key();
        build_sched(key);
        start_key(key);
        for (int r = 1; r <= 32; r++) begin
            tests_run++;
            if (bus.rk_valid !== 1'b1 || bus.rk_round !== 6'(r) || bus.rk_out !== exp_rk[r]) begin
                tests_failed++;
                $display("FAIL rst_mid_new_rk%0d got r=%0d rk=%h want r=%0d rk=%h",
                         r, bus.rk_round, bus.rk_out, r, exp_rk[r]);
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [79:0] ka;
        logic [79:0] kb;
        ka = rand_key();
        kb = rand_key();
        build_sched(ka);
        bus.rk_ready = 1'b1;
        start_key(ka);
        for (int r = 1; r <= 32; r++) begin
            tests_run++;
            if (bus.rk_round !== 6'(r) || bus.rk_out !== exp_rk[r]) begin
                tests_failed++;
                $display("FAIL b2b_a_rk%0d got r=%0d rk=%h want r=%0d rk=%h",
                         r, bus.rk_round, bus.rk_out, r, exp_rk[r]);
            end
            @(negedge clk);
        end
        tests_run++;
        if (bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done got %0b want 1", bus.done);
        end
        build_sched(kb);
        start_key(kb);
        for (int r = 1; r <= 32; r++) begin
            tests_run++;
            if (bus.rk_valid !== 1'b1 || bus.rk_round !== 6'(r) || bus.rk_out !== exp_rk[r]) begin
                tests_failed++;
                $display("FAIL b2b_b_rk%0d got v=%0b r=%0d rk=%h want v=1 r=%0d rk=%h",
                         r, bus.rk_valid, bus.rk_round, bus.rk_out, r, exp_rk[r]);
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_random_keys;
        logic [79:0] key;
        int bad;
        bus.rk_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            key = rand_key();
            build_sched(key);
            start_key(key);
            bad = 0;
            for (int r = 1; r <= 32; r++) begin
                if (bus.rk_valid !== 1'b1 || bus.rk_round !== 6'(r) || bus.rk_out !== exp_rk[r]) begin
                    if (bad == 0)
                        $display("FAIL random_key%0d_rk%0d got r=%0d rk=%h want r=%0d rk=%h",
                                 n, r, bus.rk_round, bus.rk_out, r, exp_rk[r]);
                    bad++;
                end
                @(negedge clk);
            end
            tests_run++;
            if (bad != 0 || bus.done !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_key%0d got bad=%0d d=%0b want bad=0 d=1", n, bad, bus.done);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        sbox_tbl = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        test_reset();
        test_zero_key();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_random_keys();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
